// File: rtl/pdata_strobe_ctrl.sv
// Avalon-MM fed byte FIFO driving an 8-bit parallel port with a strobe/ack handshake.
// Optional strobe timeout compiled in with `define PDATA_SEQ_TIMEOUT_EN.
module pdata_strobe_ctrl #(
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned SETUP_DEFAULT  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  out_port,
   output logic        strobe,
   input  logic        ack
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StRelease} state_e;

   state_e            state_q, state_d;
   logic [7:0]        out_q, out_d;
   logic [7:0]        setup_reg_q, setup_reg_d;
   logic [7:0]        setup_cnt_q, setup_cnt_d;
   logic              enable_q, enable_d;
   logic              ovf_q, ovf_d;
   logic              ack_s1_q, ack_s2_q;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [7:0]        mem_d [FIFO_DEPTH];

   logic wr_en, push_req, flush, empty, full, pop, push_acc, busy, tmo_bit;

`ifdef PDATA_SEQ_TIMEOUT_EN
   localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [ToW-1:0] to_cnt_q, to_cnt_d;
   logic           tmo_q, tmo_d;
   assign tmo_bit = tmo_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign tmo_bit = 1'b0;
`endif

   logic unused_wd;
   assign unused_wd = ^writedata;

   assign wr_en    = chipselect && !write_n;
   assign push_req = wr_en && (address == 2'd0);
   assign flush    = wr_en && (address == 2'd3) && writedata[1];
   assign empty    = (count_q == '0);
   assign full     = (count_q == CntW'(FIFO_DEPTH));
   assign busy     = (state_q != StIdle);
   // Flush wins over a same-cycle pop so the head byte is discarded, not sent.
   assign pop      = (state_q == StIdle) && enable_q && !empty && !flush;
   assign push_acc = push_req && !flush && (!full || pop);
   assign strobe   = (state_q == StStrobe);
   assign out_port = out_q;

   always_comb begin
      mem_d       = mem_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      setup_reg_d = setup_reg_q;
      enable_d    = enable_q;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_acc) begin
            mem_d[wr_ptr_q] = writedata[7:0];
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         count_d = count_q + CntW'(push_acc) - CntW'(pop);
      end

      if (wr_en && (address == 2'd1) && writedata[3]) ovf_d = 1'b0;
      if (push_req && !flush && !push_acc) ovf_d = 1'b1;
      if (wr_en && (address == 2'd2)) setup_reg_d = writedata[7:0];
      if (wr_en && (address == 2'd3)) enable_d = writedata[0];
   end

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      setup_cnt_d = setup_cnt_q;
`ifdef PDATA_SEQ_TIMEOUT_EN
      to_cnt_d = '0;
      tmo_d    = tmo_q;
      if (wr_en && (address == 2'd1) && writedata[4]) tmo_d = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               out_d       = mem_q[rd_ptr_q];
               setup_cnt_d = setup_reg_q;
               state_d     = StSetup;
            end
         end
         StSetup: begin
            if (setup_cnt_q == 8'd0) state_d = StStrobe;
            else                     setup_cnt_d = setup_cnt_q - 8'd1;
         end
         StStrobe: begin
            if (ack_s2_q) begin
               state_d = StRelease;
`ifdef PDATA_SEQ_TIMEOUT_EN
            end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
               // Abandon the byte: no RELEASE since the device never acked.
               state_d = StIdle;
               tmo_d   = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + ToW'(1);
`endif
            end
         end
         StRelease: begin
            if (!ack_s2_q) state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      readdata = '0;
      unique case (address)
         2'd0: readdata[7:0] = out_q;
         2'd1: readdata = {16'd0, 8'(count_q), 3'd0, tmo_bit, ovf_q, empty, full, busy};
         2'd2: readdata[7:0] = setup_reg_q;
         2'd3: readdata[0] = enable_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         out_q       <= '0;
         setup_reg_q <= 8'(SETUP_DEFAULT);
         setup_cnt_q <= '0;
         enable_q    <= 1'b0;
         ovf_q       <= 1'b0;
         ack_s1_q    <= 1'b0;
         ack_s2_q    <= 1'b0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
`ifdef PDATA_SEQ_TIMEOUT_EN
         to_cnt_q    <= '0;
         tmo_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         setup_reg_q <= setup_reg_d;
         setup_cnt_q <= setup_cnt_d;
         enable_q    <= enable_d;
         ovf_q       <= ovf_d;
         ack_s1_q    <= ack;
         ack_s2_q    <= ack_s1_q;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
`ifdef PDATA_SEQ_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
         tmo_q       <= tmo_d;
`endif
      end
   end

   // Storage needs no reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
